// File: rtl/serdesphy_pll_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serdesphy_pll_pkg : shared types and defaults for the TX PLL sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
package serdesphy_pll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_READY     = 3'd4,
    ST_FAIL      = 3'd5,
    ST_BYPASS    = 3'd6
  } pll_state_t;

  localparam int unsigned RST_CYCLES_DEF    = 16;
  localparam int unsigned LOCK_TIMEOUT_DEF  = 512;
  localparam int unsigned STABLE_CYCLES_DEF = 64;
  localparam int unsigned MAX_RETRY_DEF     = 3;

  localparam int unsigned TRIM_W    = 4;
  localparam int unsigned CP_W      = 2;
  localparam int unsigned RETRY_W   = 2;
  localparam int unsigned LOL_CNT_W = 4;

  // Never returns zero so the timer stays a legal vector for tiny parameters.
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serdesphy_pll_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serdesphy_pll_ctrl : power-up, lock qualification and retry sequencer for the TX PLL
// Revision: 1.0
// ---------------------------------------------------------------------------
module serdesphy_pll_ctrl
  import serdesphy_pll_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned MAX_RETRY     = MAX_RETRY_DEF
) (
  input  logic                 clk_ref_24m,
  input  logic                 rst_n,
  input  logic                 cfg_pll_en,
  input  logic                 cfg_bypass,
  input  logic [TRIM_W-1:0]    cfg_trim_init,
  input  logic [CP_W-1:0]      cfg_cp_current,
  input  logic                 lol_clr,
  input  logic                 pll_lock,
  output logic                 pll_enable,
  output logic                 pll_rst,
  output logic                 pll_bypass,
  output logic [TRIM_W-1:0]    vco_trim,
  output logic [CP_W-1:0]      cp_current,
  output logic                 pll_ready,
  output logic                 pll_fail,
  output logic                 lol_sticky,
  output logic [LOL_CNT_W-1:0] lol_cnt,
  output logic [RETRY_W-1:0]   retry_cnt,
  output logic [2:0]           state
);

  localparam int unsigned TIMER_W = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [TIMER_W-1:0]   RST_LAST    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0]   LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0]   STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0]   RETRY_MAX   = RETRY_W'(MAX_RETRY);
  localparam logic [LOL_CNT_W-1:0] LOL_SAT     = '1;

  pll_state_t           r_state;
  logic [TIMER_W-1:0]   r_timer;
  logic [RETRY_W-1:0]   r_retry_cnt;
  logic [TRIM_W-1:0]    r_vco_trim;
  logic [CP_W-1:0]      r_cp_current;
  logic                 r_lol_sticky;
  logic [LOL_CNT_W-1:0] r_lol_cnt;
  logic                 r_pll_enable;
  logic                 r_pll_rst;
  logic                 r_pll_bypass;
  logic                 r_pll_ready;
  logic                 r_pll_fail;

  pll_state_t           w_state_nxt;
  logic [TIMER_W-1:0]   w_timer_nxt;
  logic [RETRY_W-1:0]   w_retry_nxt;
  logic [TRIM_W-1:0]    w_trim_nxt;
  logic [CP_W-1:0]      w_cp_nxt;
  logic                 w_lol_set;
  logic                 w_sticky_nxt;
  logic [LOL_CNT_W-1:0] w_lol_cnt_nxt;
  logic                 w_timed;
  logic                 w_enable_nxt;
  logic                 w_rst_nxt;
  logic                 w_bypass_nxt;
  logic                 w_ready_nxt;
  logic                 w_fail_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry_cnt;
    w_trim_nxt  = r_vco_trim;
    w_cp_nxt    = r_cp_current;
    w_lol_set   = 1'b0;

    if (!cfg_pll_en) begin
      w_state_nxt = ST_IDLE;
    end else if (r_state != ST_BYPASS && cfg_bypass) begin
      w_state_nxt = ST_BYPASS;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_RESET;
          w_retry_nxt = '0;
          w_trim_nxt  = cfg_trim_init;
          w_cp_nxt    = cfg_cp_current;
        end
        ST_RESET: begin
          if (r_timer == RST_LAST) w_state_nxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          // A lock seen on the timeout cycle still counts as a lock.
          if (pll_lock) begin
            w_state_nxt = ST_STABLE;
          end else if (r_timer == LOCK_LAST) begin
            if (r_retry_cnt < RETRY_MAX) begin
              w_state_nxt = ST_RESET;
              w_retry_nxt = r_retry_cnt + 1'b1;
              w_trim_nxt  = r_vco_trim + 1'b1;
            end else begin
              w_state_nxt = ST_FAIL;
            end
          end
        end
        ST_STABLE: begin
          if (!pll_lock)                 w_state_nxt = ST_WAIT_LOCK;
          else if (r_timer == STABLE_LAST) w_state_nxt = ST_READY;
        end
        ST_READY: begin
          if (!pll_lock) begin
            w_state_nxt = ST_RESET;
            w_retry_nxt = '0;
            w_lol_set   = 1'b1;
          end
        end
        ST_FAIL:   w_state_nxt = ST_FAIL;
        ST_BYPASS: begin
          if (!cfg_bypass) w_state_nxt = ST_IDLE;
        end
        default:   w_state_nxt = ST_IDLE;
      endcase
    end

    w_timed = (r_state == ST_RESET) || (r_state == ST_WAIT_LOCK) || (r_state == ST_STABLE);
    if (w_state_nxt != r_state || !w_timed) w_timer_nxt = '0;
    else                                    w_timer_nxt = r_timer + 1'b1;

    w_sticky_nxt  = w_lol_set | (r_lol_sticky & ~lol_clr);
    w_lol_cnt_nxt = (w_lol_set && r_lol_cnt != LOL_SAT) ? r_lol_cnt + 1'b1 : r_lol_cnt;

    // Controls are decoded from the next state so they change together with it.
    w_enable_nxt = 1'b0;
    w_rst_nxt    = 1'b1;
    w_bypass_nxt = 1'b0;
    w_ready_nxt  = 1'b0;
    w_fail_nxt   = 1'b0;
    case (w_state_nxt)
      ST_RESET:     w_enable_nxt = 1'b1;
      ST_WAIT_LOCK,
      ST_STABLE: begin
        w_enable_nxt = 1'b1;
        w_rst_nxt    = 1'b0;
      end
      ST_READY: begin
        w_enable_nxt = 1'b1;
        w_rst_nxt    = 1'b0;
        w_ready_nxt  = 1'b1;
      end
      ST_FAIL:      w_fail_nxt = 1'b1;
      ST_BYPASS: begin
        w_bypass_nxt = 1'b1;
        w_ready_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_ref_24m or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_retry_cnt  <= '0;
      r_vco_trim   <= '0;
      r_cp_current <= '0;
      r_lol_sticky <= 1'b0;
      r_lol_cnt    <= '0;
      r_pll_enable <= 1'b0;
      r_pll_rst    <= 1'b1;
      r_pll_bypass <= 1'b0;
      r_pll_ready  <= 1'b0;
      r_pll_fail   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_retry_cnt  <= w_retry_nxt;
      r_vco_trim   <= w_trim_nxt;
      r_cp_current <= w_cp_nxt;
      r_lol_sticky <= w_sticky_nxt;
      r_lol_cnt    <= w_lol_cnt_nxt;
      r_pll_enable <= w_enable_nxt;
      r_pll_rst    <= w_rst_nxt;
      r_pll_bypass <= w_bypass_nxt;
      r_pll_ready  <= w_ready_nxt;
      r_pll_fail   <= w_fail_nxt;
    end
  end

  assign pll_enable = r_pll_enable;
  assign pll_rst    = r_pll_rst;
  assign pll_bypass = r_pll_bypass;
  assign vco_trim   = r_vco_trim;
  assign cp_current = r_cp_current;
  assign pll_ready  = r_pll_ready;
  assign pll_fail   = r_pll_fail;
  assign lol_sticky = r_lol_sticky;
  assign lol_cnt    = r_lol_cnt;
  assign retry_cnt  = r_retry_cnt;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_serdesphy_pll_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serdesphy_pll_ctrl : vector-table bench for the TX PLL sequencer (default parameters)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_serdesphy_pll_ctrl;
  import serdesphy_pll_pkg::*;

  logic       clk_ref_24m = 1'b0;
  logic       rst_n;
  logic       cfg_pll_en;
  logic       cfg_bypass;
  logic [3:0] cfg_trim_init;
  logic [1:0] cfg_cp_current;
  logic       lol_clr;
  logic       pll_lock;
  logic       pll_enable;
  logic       pll_rst;
  logic       pll_bypass;
  logic [3:0] vco_trim;
  logic [1:0] cp_current;
  logic       pll_ready;
  logic       pll_fail;
  logic       lol_sticky;
  logic [3:0] lol_cnt;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  always #5 clk_ref_24m = ~clk_ref_24m;

  serdesphy_pll_ctrl dut (
    .clk_ref_24m    (clk_ref_24m),
    .rst_n          (rst_n),
    .cfg_pll_en     (cfg_pll_en),
    .cfg_bypass     (cfg_bypass),
    .cfg_trim_init  (cfg_trim_init),
    .cfg_cp_current (cfg_cp_current),
    .lol_clr        (lol_clr),
    .pll_lock       (pll_lock),
    .pll_enable     (pll_enable),
    .pll_rst        (pll_rst),
    .pll_bypass     (pll_bypass),
    .vco_trim       (vco_trim),
    .cp_current     (cp_current),
    .pll_ready      (pll_ready),
    .pll_fail       (pll_fail),
    .lol_sticky     (lol_sticky),
    .lol_cnt        (lol_cnt),
    .retry_cnt      (retry_cnt),
    .state          (state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       en;
    logic       rst;
    logic       byp;
    logic       rdy;
    logic       fail;
    logic [3:0] trim;
    logic [1:0] cp;
    logic [1:0] retry;
    logic       sticky;
    logic [3:0] lolc;
  } outs_t;

  typedef struct {
    string      name;
    int         n;
    logic       en;
    logic       byp;
    logic       lock;
    logic       clr;
    logic [3:0] ti;
    logic [1:0] ci;
    outs_t      exp;
  } vec_t;

  vec_t  vecs[$];
  outs_t exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Expected control outputs for each state, straight from the state table.
  function automatic outs_t mk(input logic [2:0] st, input logic [3:0] tr, input logic [1:0] cp,
                               input logic [1:0] rt, input logic sk, input logic [3:0] lc);
    outs_t o;
    o = '0;
    o.st = st; o.trim = tr; o.cp = cp; o.retry = rt; o.sticky = sk; o.lolc = lc;
    o.rst = 1'b1;
    case (st)
      ST_RESET:     o.en = 1'b1;
      ST_WAIT_LOCK: begin o.en = 1'b1; o.rst = 1'b0; end
      ST_STABLE:    begin o.en = 1'b1; o.rst = 1'b0; end
      ST_READY:     begin o.en = 1'b1; o.rst = 1'b0; o.rdy = 1'b1; end
      ST_FAIL:      o.fail = 1'b1;
      ST_BYPASS:    begin o.byp = 1'b1; o.rdy = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic string fmt(input outs_t o);
    return $sformatf("st=%0d en=%b rst=%b byp=%b rdy=%b fail=%b trim=%0d cp=%0d retry=%0d sticky=%b lolcnt=%0d",
                     o.st, o.en, o.rst, o.byp, o.rdy, o.fail, o.trim, o.cp, o.retry, o.sticky, o.lolc);
  endfunction

  function automatic void add(input string nm, input int n, input logic en, input logic byp,
                              input logic lock, input logic clr, input logic [3:0] ti,
                              input logic [1:0] ci, input logic [2:0] st, input logic [3:0] tr,
                              input logic [1:0] cp, input logic [1:0] rt, input logic sk,
                              input logic [3:0] lc);
    vec_t v;
    v.name = nm; v.n = n; v.en = en; v.byp = byp; v.lock = lock; v.clr = clr;
    v.ti = ti; v.ci = ci; v.exp = mk(st, tr, cp, rt, sk, lc);
    vecs.push_back(v);
  endfunction

  task automatic check();
    outs_t act;
    outs_t exp;
    string nm;
    act = {state, pll_enable, pll_rst, pll_bypass, pll_ready, pll_fail,
           vco_trim, cp_current, retry_cnt, lol_sticky, lol_cnt};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %s, required an expected entry", fmt(act));
      return;
    end
    exp = exp_q.pop_front();
    nm  = name_q.pop_front();
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {%s} required {%s}", nm, fmt(act), fmt(exp));
    end
  endtask

  task automatic run_vec(input vec_t v);
    cfg_pll_en     = v.en;
    cfg_bypass     = v.byp;
    pll_lock       = v.lock;
    lol_clr        = v.clr;
    cfg_trim_init  = v.ti;
    cfg_cp_current = v.ci;
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
    repeat (v.n) @(posedge clk_ref_24m);
    #1;
    check();
  endtask

  initial begin
    rst_n = 1'b0; cfg_pll_en = 1'b0; cfg_bypass = 1'b0; cfg_trim_init = 4'd0;
    cfg_cp_current = 2'd0; lol_clr = 1'b0; pll_lock = 1'b0;

    //  name                  n    en byp lk clr ti  ci  state         trim cp rt sk lc
    add("enable_to_reset",     1, 1, 0, 0, 0, 5,  2, ST_RESET,     5, 2, 0, 0, 0);
    add("reset_hold",         15, 1, 0, 0, 0, 5,  2, ST_RESET,     5, 2, 0, 0, 0);
    add("reset_to_wait",       1, 1, 0, 0, 0, 5,  2, ST_WAIT_LOCK, 5, 2, 0, 0, 0);
    add("wait_240_cfg_frozen",240,1, 0, 0, 0, 9,  3, ST_WAIT_LOCK, 5, 2, 0, 0, 0);
    add("lock_to_stable",      1, 1, 0, 1, 0, 9,  3, ST_STABLE,    5, 2, 0, 0, 0);
    add("stable_hold",        63, 1, 0, 1, 0, 9,  3, ST_STABLE,    5, 2, 0, 0, 0);
    add("ready_at_322",        1, 1, 0, 1, 0, 9,  3, ST_READY,     5, 2, 0, 0, 0);
    add("lol_to_reset",        1, 1, 0, 0, 0, 9,  3, ST_RESET,     5, 2, 0, 1, 1);
    add("relock_wait",        16, 1, 0, 0, 0, 9,  3, ST_WAIT_LOCK, 5, 2, 0, 1, 1);
    add("unstable_enter",      1, 1, 0, 1, 0, 9,  3, ST_STABLE,    5, 2, 0, 1, 1);
    add("unstable_hold",       9, 1, 0, 1, 0, 9,  3, ST_STABLE,    5, 2, 0, 1, 1);
    add("unstable_drop",       1, 1, 0, 0, 0, 9,  3, ST_WAIT_LOCK, 5, 2, 0, 1, 1);
    add("stable_retry",        1, 1, 0, 1, 0, 9,  3, ST_STABLE,    5, 2, 0, 1, 1);
    add("ready_again",        64, 1, 0, 1, 0, 9,  3, ST_READY,     5, 2, 0, 1, 1);
    add("lol_set_beats_clr",   1, 1, 0, 0, 1, 9,  3, ST_RESET,     5, 2, 0, 1, 2);
    add("lol_clr_alone",       1, 1, 0, 0, 1, 9,  3, ST_RESET,     5, 2, 0, 0, 2);
    add("abort_in_reset",      1, 0, 0, 0, 0, 9,  3, ST_IDLE,      5, 2, 0, 0, 2);
    add("retry_start",         1, 1, 0, 0, 0, 15, 1, ST_RESET,    15, 1, 0, 0, 2);
    add("retry_wait0",        16, 1, 0, 0, 0, 15, 1, ST_WAIT_LOCK,15, 1, 0, 0, 2);
    add("retry_wait0_hold",  511, 1, 0, 0, 0, 15, 1, ST_WAIT_LOCK,15, 1, 0, 0, 2);
    add("retry1_wrap",         1, 1, 0, 0, 0, 15, 1, ST_RESET,     0, 1, 1, 0, 2);
    add("retry2",            528, 1, 0, 0, 0, 15, 1, ST_RESET,     1, 1, 2, 0, 2);
    add("retry3",            528, 1, 0, 0, 0, 15, 1, ST_RESET,     2, 1, 3, 0, 2);
    add("retry3_wait",        16, 1, 0, 0, 0, 15, 1, ST_WAIT_LOCK, 2, 1, 3, 0, 2);
    add("retry3_wait_hold",  511, 1, 0, 0, 0, 15, 1, ST_WAIT_LOCK, 2, 1, 3, 0, 2);
    add("fail",                1, 1, 0, 0, 0, 15, 1, ST_FAIL,      2, 1, 3, 0, 2);
    add("fail_hold",           5, 1, 0, 0, 0, 15, 1, ST_FAIL,      2, 1, 3, 0, 2);
    add("fail_exit",           1, 0, 0, 0, 0, 15, 1, ST_IDLE,      2, 1, 3, 0, 2);
    add("byp_seq_reset",       1, 1, 0, 0, 0, 3,  0, ST_RESET,     3, 0, 0, 0, 2);
    add("byp_seq_wait",       16, 1, 0, 0, 0, 3,  0, ST_WAIT_LOCK, 3, 0, 0, 0, 2);
    add("bypass_enter",        1, 1, 1, 0, 0, 3,  0, ST_BYPASS,    3, 0, 0, 0, 2);
    add("bypass_hold",         3, 1, 1, 0, 0, 3,  0, ST_BYPASS,    3, 0, 0, 0, 2);
    add("bypass_release",      1, 1, 0, 0, 0, 3,  0, ST_IDLE,      3, 0, 0, 0, 2);
    add("resequence",          1, 1, 0, 0, 0, 3,  0, ST_RESET,     3, 0, 0, 0, 2);
    add("reseq_wait",         16, 1, 0, 0, 0, 3,  0, ST_WAIT_LOCK, 3, 0, 0, 0, 2);
    add("reseq_stable",        1, 1, 0, 1, 0, 3,  0, ST_STABLE,    3, 0, 0, 0, 2);

    repeat (3) @(posedge clk_ref_24m);
    #1;
    exp_q.push_back(mk(ST_IDLE, 0, 0, 0, 0, 0));
    name_q.push_back("reset_values");
    check();
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Asynchronous reset in the middle of STABLE, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(ST_IDLE, 0, 0, 0, 0, 0));
    name_q.push_back("async_reset_mid_stable");
    check();
    cfg_pll_en = 1'b0;
    @(posedge clk_ref_24m);
    #1;
    rst_n = 1'b1;
    @(posedge clk_ref_24m);
    #1;
    exp_q.push_back(mk(ST_IDLE, 0, 0, 0, 0, 0));
    name_q.push_back("idle_after_reset_release");
    check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
